// File: rtl/cam_i2c_pkg.sv
// Shared definitions for the IR camera I2C target: FSM states, default
// target address and the camera register map used by the controller.
package cam_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h58;

  localparam logic [7:0] REG_CONTROL     = 8'h30;
  localparam logic [7:0] REG_SENSITIVITY = 8'h06;
  localparam logic [7:0] REG_DATA_START  = 8'h36;

  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_ACK  = 4'd8;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchroniser for SCL/SDA. Two flops per line bring the pad into the
// clock domain and a third history flop lets us see edges. START/STOP are
// SDA edges while SCL is (and was) high.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;
  logic       w_scl;
  logic       w_sda;

  // Synchroniser chains reset to the idle-bus level so reset makes no edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
    end
  end

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_hist;
  assign o_scl_fall = ~w_scl & r_scl_hist;
  assign o_start    = w_scl & r_scl_hist & ~w_sda & r_sda_hist;
  assign o_stop     = w_scl & r_scl_hist & w_sda & ~r_sda_hist;

endmodule

// File: rtl/ir_cam_i2c_target.sv
// I2C target emulating the IR camera. Decodes address, loads the register
// pointer, emits write strobes and serves reads from external storage.
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | not addressed, waiting for START
// ST_ADDR      | shifting in {addr[6:0], rw}
// ST_ADDR_ACK  | driving ACK for our address (9th clock)
// ST_PTR       | shifting in register pointer
// ST_PTR_ACK   | driving ACK for pointer byte
// ST_WDATA     | shifting in a data byte to write
// ST_WDATA_ACK | driving ACK for data byte, pointer advances after it
// ST_RDATA     | shifting out rd_data MSB first
// ST_RACK      | SDA released, sampling controller ACK/NACK
module ir_cam_i2c_target
  import cam_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         PTR_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_scl_in,
  input  logic             i_sda_in,
  output logic             o_sda_oe,
  output logic             o_wr_stb,
  output logic [PTR_W-1:0] o_wr_addr,
  output logic [7:0]       o_wr_data,
  output logic [PTR_W-1:0] o_rd_addr,
  input  logic [7:0]       i_rd_data,
  output logic             o_busy
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_bus_sync u_sync (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_scl      (i_scl_in),
    .i_sda      (i_sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t           r_state,   w_state_nx;
  logic [3:0]       r_cnt,     w_cnt_nx;
  logic [7:0]       r_shift,   w_shift_nx;
  logic             r_rw,      w_rw_nx;
  logic [PTR_W-1:0] r_rd_addr, w_rd_addr_nx;
  logic [PTR_W-1:0] r_wr_addr, w_wr_addr_nx;
  logic [7:0]       r_wr_data, w_wr_data_nx;
  logic             r_wr_stb,  w_wr_stb_nx;
  logic             r_sda_oe,  w_sda_oe_nx;
  logic             r_busy,    w_busy_nx;

  logic [7:0] w_byte;
  logic       w_last_bit;

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last_bit = (r_cnt == BIT_LAST);

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_stb  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_shift   <= w_shift_nx;
      r_rw      <= w_rw_nx;
      r_rd_addr <= w_rd_addr_nx;
      r_wr_addr <= w_wr_addr_nx;
      r_wr_data <= w_wr_data_nx;
      r_wr_stb  <= w_wr_stb_nx;
      r_sda_oe  <= w_sda_oe_nx;
      r_busy    <= w_busy_nx;
    end
  end

  // Next-state logic. In the ACK states r_sda_oe doubles as the phase flag:
  // the first SCL fall starts driving ACK, the second one ends it.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_shift_nx   = r_shift;
    w_rw_nx      = r_rw;
    w_rd_addr_nx = r_rd_addr;
    w_wr_addr_nx = r_wr_addr;
    w_wr_data_nx = r_wr_data;
    w_wr_stb_nx  = 1'b0;
    w_sda_oe_nx  = r_sda_oe;
    w_busy_nx    = r_busy;

    if (w_stop) begin
      w_state_nx  = ST_IDLE;
      w_cnt_nx    = '0;
      w_sda_oe_nx = 1'b0;
      w_busy_nx   = 1'b0;
    end else if (w_start) begin
      w_state_nx  = ST_ADDR;
      w_cnt_nx    = '0;
      w_sda_oe_nx = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
            if (w_last_bit) begin
              w_cnt_nx = '0;
              if (w_byte[7:1] == DEV_ADDR) begin
                w_state_nx = ST_ADDR_ACK;
                w_rw_nx    = w_byte[0];
                w_busy_nx  = 1'b1;
              end else begin
                w_state_nx = ST_IDLE;
                w_busy_nx  = 1'b0;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nx = 1'b1;
            end else if (r_rw) begin
              // This fall also opens the first read byte.
              w_state_nx  = ST_RDATA;
              w_cnt_nx    = '0;
              w_shift_nx  = i_rd_data;
              w_sda_oe_nx = ~i_rd_data[7];
            end else begin
              w_state_nx  = ST_PTR;
              w_cnt_nx    = '0;
              w_sda_oe_nx = 1'b0;
            end
          end
        end

        ST_PTR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
            if (w_last_bit) begin
              w_cnt_nx     = '0;
              w_rd_addr_nx = PTR_W'(w_byte);
              w_state_nx   = ST_PTR_ACK;
            end
          end
        end

        ST_PTR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nx = 1'b1;
            end else begin
              w_sda_oe_nx = 1'b0;
              w_state_nx  = ST_WDATA;
            end
          end
        end

        ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
            if (w_last_bit) begin
              w_cnt_nx     = '0;
              w_wr_stb_nx  = 1'b1;
              w_wr_addr_nx = r_rd_addr;
              w_wr_data_nx = w_byte;
              w_state_nx   = ST_WDATA_ACK;
            end
          end
        end

        ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nx = 1'b1;
            end else begin
              w_sda_oe_nx  = 1'b0;
              w_rd_addr_nx = r_rd_addr + PTR_ONE;
              w_state_nx   = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              w_shift_nx  = i_rd_data;
              w_sda_oe_nx = ~i_rd_data[7];
            end else if (r_cnt == BIT_ACK) begin
              w_cnt_nx    = '0;
              w_sda_oe_nx = 1'b0;
              w_state_nx  = ST_RACK;
            end else begin
              w_shift_nx  = {r_shift[6:0], 1'b0};
              w_sda_oe_nx = ~r_shift[6];
            end
          end
        end

        ST_RACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_rd_addr_nx = r_rd_addr + PTR_ONE;
              w_cnt_nx     = '0;
              w_state_nx   = ST_RDATA;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end
        end

        default: begin
          w_state_nx  = ST_IDLE;
          w_sda_oe_nx = 1'b0;
        end
      endcase
    end
  end

  assign o_sda_oe  = r_sda_oe;
  assign o_wr_stb  = r_wr_stb;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_rd_addr = r_rd_addr;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_ir_cam_i2c_target.sv
// Bench for ir_cam_i2c_target: bit-banged I2C controller on an open-drain
// bus, a fixed register image behind rd_data, and a transaction-level model
// of pointer/write behaviour.
module tb_ir_cam_i2c_target;

  typedef logic [7:0] byte_q_t[$];
  typedef logic       bit_q_t[$];

  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [7:0] regs [0:255];

  assign sda_bus = sda_drv & ~sda_oe;
  assign rd_data = regs[rd_addr];

  // 100 MHz system clock.
  always #5 clk = ~clk;

  ir_cam_i2c_target dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_scl_in  (scl_drv),
    .i_sda_in  (sda_bus),
    .o_sda_oe  (sda_oe),
    .o_wr_stb  (wr_stb),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_rd_addr (rd_addr),
    .i_rd_data (rd_data),
    .o_busy    (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] obs_log [0:1023];
  int          obs_n = 0;
  int          obs_rd = 0;
  int          oe_cycles = 0;

  // Record every write strobe and count cycles where SDA is pulled.
  always @(negedge clk) begin
    if (wr_stb) begin
      obs_log[obs_n % 1024] = {wr_addr, wr_data};
      obs_n++;
    end
    if (sda_oe) oe_cycles++;
  end

  // Reference model: pointer plus queue of expected writes.
  int          m_ptr = 0;
  logic [15:0] exp_q[$];

  function automatic void model_write(input logic [6:0] a, input byte_q_t data);
    if (a != 7'h58) return;
    foreach (data[i]) begin
      if (i == 0) m_ptr = int'(data[0]);
      else begin
        exp_q.push_back({m_ptr[7:0], data[i]});
        m_ptr = (m_ptr + 1) % 256;
      end
    end
  endfunction

  task automatic bus_start();
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b1; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    sda_drv = b; #Q;
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    b = sda_bus; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic do_write(input logic [6:0] a, input byte_q_t data,
                          input bit with_stop, output bit_q_t acks);
    logic ack;
    acks = {};
    bus_start();
    send_byte({a, 1'b0}, ack);
    acks.push_back(ack);
    if (ack == 1'b0) begin
      foreach (data[i]) begin
        send_byte(data[i], ack);
        acks.push_back(ack);
      end
    end
    if (with_stop) bus_stop();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    n_vec++; if (wr_stb !== 1'b0) begin n_err++; $display("FAIL reset_wr_stb: got %b expected 0", wr_stb); end
    n_vec++; if (wr_addr !== 8'h00) begin n_err++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    n_vec++; if (rd_addr !== 8'h00) begin n_err++; $display("FAIL reset_rd_addr: got %h expected 00", rd_addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_cfg_write();
    logic [15:0] cfg [3] = '{16'h3001, 16'h3008, 16'h0690};
    byte_q_t tx;
    bit_q_t  acks;
    for (int k = 0; k < 3; k++) begin
      tx = {};
      tx.push_back(cfg[k][15:8]);
      tx.push_back(cfg[k][7:0]);
      do_write(7'h58, tx, 1'b0, acks);
      model_write(7'h58, tx);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cfg_busy_mid: got %b expected 1", busy); end
      bus_stop();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cfg_busy_stop: got %b expected 0", busy); end
      n_vec++; if (acks.size() != 3) begin n_err++; $display("FAIL cfg_ack_count: got %0d expected 3", acks.size()); end
      foreach (acks[i]) begin
        n_vec++; if (acks[i] !== 1'b0) begin n_err++; $display("FAIL cfg_ack%0d: got %b expected 0", i, acks[i]); end
      end
      n_vec++; if (obs_n - obs_rd != exp_q.size()) begin n_err++; $display("FAIL cfg_wr_count: got %0d expected %0d", obs_n - obs_rd, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_n) begin
        n_vec++; if (obs_log[obs_rd % 1024] !== exp_q[0]) begin n_err++; $display("FAIL cfg_wr: got %h expected %h", obs_log[obs_rd % 1024], exp_q[0]); end
        void'(exp_q.pop_front()); obs_rd++;
      end
      exp_q.delete(); obs_rd = obs_n;
    end
  endtask

  task automatic test_wrong_addr();
    byte_q_t tx;
    bit_q_t  acks;
    int      oe0;
    oe0 = oe_cycles;
    tx = {};
    tx.push_back(8'h30);
    do_write(7'h5A, tx, 1'b0, acks);
    model_write(7'h5A, tx);
    n_vec++; if (acks[0] !== 1'b1) begin n_err++; $display("FAIL wrong_addr_ack: got %b expected 1", acks[0]); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrong_addr_busy: got %b expected 0", busy); end
    bus_stop();
    n_vec++; if (oe_cycles != oe0) begin n_err++; $display("FAIL wrong_addr_oe: got %0d driven cycles expected 0", oe_cycles - oe0); end
    n_vec++; if (obs_n != obs_rd) begin n_err++; $display("FAIL wrong_addr_wr: got %0d strobes expected 0", obs_n - obs_rd); end
    obs_rd = obs_n;
  endtask

  task automatic test_ptr_read();
    byte_q_t    tx;
    bit_q_t     acks;
    logic       ack;
    logic [7:0] d;
    logic [7:0] expd;
    tx = {};
    tx.push_back(8'h36);
    do_write(7'h58, tx, 1'b0, acks);
    model_write(7'h58, tx);
    n_vec++; if (acks.size() != 2 || acks[0] !== 1'b0 || acks[1] !== 1'b0) begin n_err++; $display("FAIL ptr_ack: got %0d acks expected 2 low", acks.size()); end
    bus_start();
    send_byte({7'h58, 1'b1}, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b expected 0", ack); end
    for (int k = 0; k < 3; k++) begin
      expd = regs[m_ptr];
      recv_byte(k == 2, d);
      n_vec++; if (d !== expd) begin n_err++; $display("FAIL rd_byte%0d: got %h expected %h", k, d, expd); end
      if (k != 2) m_ptr = (m_ptr + 1) % 256;
    end
    bus_stop();
    n_vec++; if (rd_addr !== m_ptr[7:0]) begin n_err++; $display("FAIL rd_ptr_end: got %h expected %h", rd_addr, m_ptr[7:0]); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    byte_q_t tx;
    bit_q_t  acks;
    tx = {};
    tx.push_back(8'hFE); tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
    do_write(7'h58, tx, 1'b1, acks);
    model_write(7'h58, tx);
    foreach (acks[i]) begin
      n_vec++; if (acks[i] !== 1'b0) begin n_err++; $display("FAIL wrap_ack%0d: got %b expected 0", i, acks[i]); end
    end
    n_vec++; if (obs_n - obs_rd != exp_q.size()) begin n_err++; $display("FAIL wrap_wr_count: got %0d expected %0d", obs_n - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_n) begin
      n_vec++; if (obs_log[obs_rd % 1024] !== exp_q[0]) begin n_err++; $display("FAIL wrap_wr: got %h expected %h", obs_log[obs_rd % 1024], exp_q[0]); end
      void'(exp_q.pop_front()); obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_n;
    n_vec++; if (rd_addr !== m_ptr[7:0]) begin n_err++; $display("FAIL wrap_ptr: got %h expected %h", rd_addr, m_ptr[7:0]); end
  endtask

  task automatic test_partial_stop();
    byte_q_t tx;
    bit_q_t  acks;
    int      oe0;
    tx = {};
    tx.push_back(8'h40);
    do_write(7'h58, tx, 1'b0, acks);
    model_write(7'h58, tx);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    bus_stop();
    n_vec++; if (obs_n != obs_rd) begin n_err++; $display("FAIL partial_wr: got %0d strobes expected 0", obs_n - obs_rd); end
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL partial_sda_oe: got %b expected 0", sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL partial_busy: got %b expected 0", busy); end
    n_vec++; if (rd_addr !== m_ptr[7:0]) begin n_err++; $display("FAIL partial_ptr: got %h expected %h", rd_addr, m_ptr[7:0]); end
    oe0 = oe_cycles;
    scl_drv = 1'b0; #Q;
    repeat (9) put_bit(1'b0);
    bus_stop();
    n_vec++; if (oe_cycles != oe0 || obs_n != obs_rd) begin n_err++; $display("FAIL partial_idle: got %0d driven cycles, %0d strobes expected 0", oe_cycles - oe0, obs_n - obs_rd); end
    obs_rd = obs_n;
  endtask

  task automatic test_reset_during_ack();
    byte_q_t    tx;
    bit_q_t     acks;
    logic [7:0] a;
    a = {7'h58, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(a[i]);
    @(negedge clk);
    n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rst_ack_driven: got %b expected 1", sda_oe); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_ack_release: got %b expected 0", sda_oe); end
    reset = 1'b0;
    m_ptr = 0;
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #Q;
    bus_stop();
    tx = {};
    tx.push_back(8'h30); tx.push_back(8'h08);
    do_write(7'h58, tx, 1'b1, acks);
    model_write(7'h58, tx);
    n_vec++; if (acks.size() != 3) begin n_err++; $display("FAIL rst_next_ack_count: got %0d expected 3", acks.size()); end
    foreach (acks[i]) begin
      n_vec++; if (acks[i] !== 1'b0) begin n_err++; $display("FAIL rst_next_ack%0d: got %b expected 0", i, acks[i]); end
    end
    n_vec++; if (obs_n - obs_rd != exp_q.size()) begin n_err++; $display("FAIL rst_next_wr_count: got %0d expected %0d", obs_n - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_n) begin
      n_vec++; if (obs_log[obs_rd % 1024] !== exp_q[0]) begin n_err++; $display("FAIL rst_next_wr: got %h expected %h", obs_log[obs_rd % 1024], exp_q[0]); end
      void'(exp_q.pop_front()); obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_n;
  endtask

  task automatic test_random();
    byte_q_t    tx;
    bit_q_t     acks;
    logic       ack;
    logic       nack;
    logic       exp_ack;
    logic [7:0] d;
    logic [7:0] expd;
    logic [6:0] a;
    int         n;
    int         kind;
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      if (kind != 1) begin
        a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h58;
        if (kind == 2) a = 7'h58;
        n = (kind == 2) ? 1 : $urandom_range(1, 4);
        tx = {};
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
        do_write(a, tx, kind == 0, acks);
        model_write(a, tx);
        exp_ack = (a == 7'h58) ? 1'b0 : 1'b1;
        n_vec++; if (acks.size() != ((a == 7'h58) ? n + 1 : 1)) begin n_err++; $display("FAIL rnd_ack_count: got %0d expected %0d", acks.size(), (a == 7'h58) ? n + 1 : 1); end
        foreach (acks[i]) begin
          n_vec++; if (acks[i] !== exp_ack) begin n_err++; $display("FAIL rnd_ack%0d: got %b expected %b", i, acks[i], exp_ack); end
        end
      end
      if (kind != 0) begin
        bus_start();
        send_byte({7'h58, 1'b1}, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rnd_rd_addr_ack: got %b expected 0", ack); end
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          nack = (i == n - 1);
          expd = regs[m_ptr];
          recv_byte(nack, d);
          n_vec++; if (d !== expd) begin n_err++; $display("FAIL rnd_rd_byte: got %h expected %h", d, expd); end
          if (!nack) m_ptr = (m_ptr + 1) % 256;
        end
        bus_stop();
      end
      n_vec++; if (obs_n - obs_rd != exp_q.size()) begin n_err++; $display("FAIL rnd_wr_count: got %0d expected %0d", obs_n - obs_rd, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_n) begin
        n_vec++; if (obs_log[obs_rd % 1024] !== exp_q[0]) begin n_err++; $display("FAIL rnd_wr: got %h expected %h", obs_log[obs_rd % 1024], exp_q[0]); end
        void'(exp_q.pop_front()); obs_rd++;
      end
      exp_q.delete(); obs_rd = obs_n;
      n_vec++; if (rd_addr !== m_ptr[7:0]) begin n_err++; $display("FAIL rnd_ptr: got %h expected %h", rd_addr, m_ptr[7:0]); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_busy: got %b expected 0", busy); end
    end
  endtask

  // Watchdog: the bench is purely time-driven, this only guards against a runaway.
  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  // Test sequence.
  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    regs[8'h36] = 8'hA5;
    regs[8'h37] = 8'h3C;
    regs[8'h38] = 8'hFF;
    test_reset();
    test_cfg_write();
    test_wrong_addr();
    test_ptr_read();
    test_wrap();
    test_partial_stop();
    test_reset_during_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
